// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: valid/ready bus, flush and counter for the immediate extender.
interface imm_extend_unit_if #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [15:0]           in_instr;
   logic [3:0]            in_sel;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_imm;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic                  out_illegal;
   logic [CNT_WIDTH-1:0]  illegal_count;
   modport master (
      output flush, in_valid, in_instr, in_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal, illegal_count
   );
   modport slave (
      input  flush, in_valid, in_instr, in_sel, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal, illegal_count
   );
endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extractor/extender with a 2-entry skid buffer.
module imm_extend_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input logic             clk,
   input logic             rst,
   imm_extend_unit_if.slave bus
);
   logic                  outValid, skidValid, outIll, skidIll, newIll, sx, acc;
   logic [DATA_WIDTH-1:0] outImm, skidImm, newImm;
   logic [TAG_WIDTH-1:0]  outTag, skidTag;
   logic [CNT_WIDTH-1:0]  illCnt;
   logic [15:0]           instr;
   logic [2:0]            code;
   assign instr = bus.in_instr;
   assign code  = bus.in_sel[2:0];
   assign sx    = bus.in_sel[3];
   always_comb begin
      newImm = '0;
      newIll = 1'b0;
      case (code)
         3'd0: newImm = {{(DATA_WIDTH-8){sx & instr[7]}}, instr[7:0]};
         3'd1: newImm = {{(DATA_WIDTH-4){sx & instr[3]}}, instr[3:0]};
         3'd2: newImm = {{(DATA_WIDTH-5){sx & instr[4]}}, instr[4:0]};
         3'd3: newImm = {{(DATA_WIDTH-11){sx & instr[10]}}, instr[10:0]};
         3'd4: newImm = {{(DATA_WIDTH-3){sx & instr[4]}}, instr[4:2]};
         3'd5: newImm = {{(DATA_WIDTH-4){1'b0}}, instr[4:2] == 3'd0 ? 4'd8 : {1'b0, instr[4:2]}};
         default: newIll = 1'b1;
      endcase
   end
   // in_ready depends only on registered state, so out_ready never reaches it combinationally
   assign bus.in_ready = !skidValid && !rst;
   assign acc = bus.in_valid && bus.in_ready && !bus.flush;
   always_ff @(posedge clk) begin
      if (rst) begin
         outValid  <= 1'b0;
         outImm    <= '0;
         outTag    <= '0;
         outIll    <= 1'b0;
         skidValid <= 1'b0;
         skidImm   <= '0;
         skidTag   <= '0;
         skidIll   <= 1'b0;
         illCnt    <= '0;
      end else if (bus.flush) begin
         outValid  <= 1'b0;
         skidValid <= 1'b0;
      end else begin
         if (!outValid || bus.out_ready) begin
            if (skidValid) begin
               outImm    <= skidImm;
               outTag    <= skidTag;
               outIll    <= skidIll;
               skidValid <= 1'b0;
            end else if (acc) begin
               outImm <= newImm;
               outTag <= bus.in_tag;
               outIll <= newIll;
            end
            outValid <= skidValid || acc;
         end else if (acc) begin
            skidValid <= 1'b1;
            skidImm   <= newImm;
            skidTag   <= bus.in_tag;
            skidIll   <= newIll;
         end
         if (acc && newIll && !(&illCnt)) illCnt <= illCnt + 1'b1;
      end
   end
   assign bus.out_valid     = outValid;
   assign bus.out_imm       = outImm;
   assign bus.out_tag       = outTag;
   assign bus.out_illegal   = outIll;
   assign bus.illegal_count = illCnt;
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed checks of extension, skid back-pressure, flush, reset and saturation.
module tb_imm_extend_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   imm_extend_unit_if #(.DATA_WIDTH(16)) b16 ();
   imm_extend_unit_if #(.DATA_WIDTH(32)) b32 ();
   imm_extend_unit #(.DATA_WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
   imm_extend_unit #(.DATA_WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic [15:0] instr, input logic [3:0] sel, input logic [15:0] tag);
      b16.in_valid = 1'b1;
      b16.in_instr = instr;
      b16.in_sel   = sel;
      b16.in_tag   = tag;
   endtask
   task automatic xfer(input string name, input logic [15:0] instr, input logic [3:0] sel,
                       input logic [15:0] tag, input logic [15:0] expImm);
      drive(instr, sel, tag);
      step;
      chk({name, " valid"}, 32'(b16.out_valid), 32'd1);
      chk({name, " imm"}, 32'(b16.out_imm), 32'(expImm));
      chk({name, " tag"}, 32'(b16.out_tag), 32'(tag));
      chk({name, " illegal"}, 32'(b16.out_illegal), 32'd0);
   endtask
   task automatic chkReset(input string name);
      chk({name, " out_valid"}, 32'(b16.out_valid), 32'd0);
      chk({name, " out_imm"}, 32'(b16.out_imm), 32'd0);
      chk({name, " out_tag"}, 32'(b16.out_tag), 32'd0);
      chk({name, " out_illegal"}, 32'(b16.out_illegal), 32'd0);
      chk({name, " count"}, 32'(b16.illegal_count), 32'd0);
      chk({name, " in_ready"}, 32'(b16.in_ready), 32'd0);
   endtask
   initial begin
      b16.flush = 0; b16.in_valid = 0; b16.in_instr = 0; b16.in_sel = 0; b16.in_tag = 0; b16.out_ready = 1;
      b32.flush = 0; b32.in_valid = 0; b32.in_instr = 0; b32.in_sel = 0; b32.in_tag = 0; b32.out_ready = 1;
      step;
      step;
      chkReset("reset");
      chk("reset 32 valid", 32'(b32.out_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("ready after reset", 32'(b16.in_ready), 32'd1);
      // extension vectors, back-to-back with out_ready high
      xfer("zext8", 16'h00F5, 4'b0000, 16'h0001, 16'h00F5);
      xfer("sext8", 16'h00F5, 4'b1000, 16'h0002, 16'hFFF5);
      xfer("sext11", 16'h0400, 4'b1011, 16'h0003, 16'hFC00);
      xfer("sext3", 16'h0010, 4'b1100, 16'h0004, 16'hFFFC);
      xfer("c8 zero", 16'h0000, 4'b0101, 16'h0005, 16'h0008);
      xfer("c8 sign", 16'h0000, 4'b1101, 16'h0006, 16'h0008);
      xfer("c8 nz", 16'h001C, 4'b1101, 16'h0007, 16'h0007);
      xfer("zext4", 16'h00FA, 4'b0001, 16'h0008, 16'h000A);
      xfer("sext4", 16'h00FA, 4'b1001, 16'h0009, 16'hFFFA);
      xfer("sext5", 16'h0011, 4'b1010, 16'h000A, 16'hFFF1);
      xfer("zext5", 16'h0011, 4'b0010, 16'h000B, 16'h0011);
      xfer("zext11", 16'hFC00, 4'b0011, 16'h000C, 16'h0400);
      b16.in_valid = 0;
      step;
      chk("idle valid", 32'(b16.out_valid), 32'd0);
      chk("no illegal yet", 32'(b16.illegal_count), 32'd0);
      // 32-bit instance
      b32.in_valid = 1; b32.in_instr = 16'h00F5; b32.in_sel = 4'b1000; b32.in_tag = 16'h0077;
      step;
      chk("w32 sext8", b32.out_imm, 32'hFFFFFFF5);
      chk("w32 tag", 32'(b32.out_tag), 32'h0077);
      b32.in_instr = 16'h000F; b32.in_sel = 4'b0001;
      step;
      chk("w32 zext4", b32.out_imm, 32'h0000000F);
      b32.in_valid = 0;
      // back-pressure: tags 1..4, out_ready low for 3 edges
      b16.out_ready = 0;
      drive(16'h0011, 4'b0000, 16'd1);
      step;
      chk("bp out1 tag", 32'(b16.out_tag), 32'd1);
      chk("bp ready1", 32'(b16.in_ready), 32'd1);
      drive(16'h0022, 4'b0000, 16'd2);
      step;
      chk("bp stall tag", 32'(b16.out_tag), 32'd1);
      chk("bp ready drop", 32'(b16.in_ready), 32'd0);
      drive(16'h0033, 4'b0000, 16'd3);
      step;
      chk("bp stable valid", 32'(b16.out_valid), 32'd1);
      chk("bp stable tag", 32'(b16.out_tag), 32'd1);
      chk("bp stable imm", 32'(b16.out_imm), 32'h0011);
      chk("bp still blocked", 32'(b16.in_ready), 32'd0);
      b16.out_ready = 1;
      step;
      chk("bp skid out tag", 32'(b16.out_tag), 32'd2);
      chk("bp skid out imm", 32'(b16.out_imm), 32'h0022);
      chk("bp ready back", 32'(b16.in_ready), 32'd1);
      step;
      chk("bp out3 tag", 32'(b16.out_tag), 32'd3);
      chk("bp out3 imm", 32'(b16.out_imm), 32'h0033);
      drive(16'h0044, 4'b0000, 16'd4);
      step;
      chk("bp out4 tag", 32'(b16.out_tag), 32'd4);
      b16.in_valid = 0;
      step;
      chk("bp drained", 32'(b16.out_valid), 32'd0);
      // flush with OUT and SKID full
      b16.out_ready = 0;
      drive(16'h0000, 4'b0110, 16'h00A0);
      step;
      chk("fl out illegal", 32'(b16.out_illegal), 32'd1);
      chk("fl out imm zero", 32'(b16.out_imm), 32'd0);
      drive(16'h0012, 4'b0000, 16'h00B0);
      step;
      chk("fl count 1", 32'(b16.illegal_count), 32'd1);
      chk("fl skid full", 32'(b16.in_ready), 32'd0);
      b16.flush = 1;
      drive(16'h0000, 4'b0110, 16'h00C0);
      step;
      b16.flush = 0; b16.in_valid = 0;
      chk("fl valid", 32'(b16.out_valid), 32'd0);
      chk("fl ready", 32'(b16.in_ready), 32'd1);
      chk("fl count", 32'(b16.illegal_count), 32'd1);
      step;
      chk("fl no ghost", 32'(b16.out_valid), 32'd0);
      // flush with a concurrent input that would otherwise be accepted
      drive(16'h0013, 4'b0000, 16'h00D0);
      step;
      b16.flush = 1;
      drive(16'h0000, 4'b0111, 16'h00E0);
      step;
      b16.flush = 0; b16.in_valid = 0;
      chk("fl2 valid", 32'(b16.out_valid), 32'd0);
      chk("fl2 count", 32'(b16.illegal_count), 32'd1);
      step;
      chk("fl2 dropped", 32'(b16.out_valid), 32'd0);
      // reset mid-stall
      drive(16'h0000, 4'b0110, 16'h0F01);
      step;
      drive(16'h0014, 4'b0000, 16'h0F02);
      step;
      chk("rs count", 32'(b16.illegal_count), 32'd2);
      chk("rs stalled", 32'(b16.in_ready), 32'd0);
      rst = 1;
      drive(16'h0015, 4'b0000, 16'h0F03);
      step;
      chkReset("rs mid");
      rst = 0;
      b16.out_ready = 1;
      drive(16'h0033, 4'b0000, 16'h0055);
      #1;
      chk("rs ready", 32'(b16.in_ready), 32'd1);
      step;
      b16.in_valid = 0;
      chk("rs first valid", 32'(b16.out_valid), 32'd1);
      chk("rs first tag", 32'(b16.out_tag), 32'h0055);
      chk("rs first imm", 32'(b16.out_imm), 32'h0033);
      // illegal saturation
      for (int i = 0; i < 300; i++) begin
         drive(16'(i * 7 + 3), 4'b0110, 16'(i));
         step;
         chk("ill flag", 32'(b16.out_illegal), 32'd1);
         chk("ill imm", 32'(b16.out_imm), 32'd0);
         chk("ill count", 32'(b16.illegal_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      end
      b16.in_valid = 0;
      step;
      chk("ill final", 32'(b16.illegal_count), 32'd255);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Registered, parametrised immediate extractor/extender for the decode stage of the 16-bit pipelined CPU. Selects an immediate field from the instruction word, zero- or sign-extends it to DATA_WIDTH, and presents it with a carried tag through a valid/ready interface. A 2-entry skid buffer absorbs back-pressure without combinational paths from the downstream ready to the upstream ready. The block also counts illegal select codes.

## Interface
- DATA_WIDTH, 16, width of extended immediate; must be >= 16
- TAG_WIDTH, 16, width of sideband tag carried alongside (e.g. PC)
- CNT_WIDTH, 8, width of saturating illegal-select counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input item present
- in_ready  out  1  block can accept an item this cycle
- in_instr  in  16  instruction word
- in_sel  in  4  bit3: 1 = sign-extend, 0 = zero-extend; bits[2:0]: field code
- in_tag  in  TAG_WIDTH  sideband, passed through unchanged
- out_valid  out  1  output item present
- out_ready  in  1  downstream accepts the output this cycle
- out_imm  out  DATA_WIDTH  extended immediate
- out_tag  out  TAG_WIDTH  tag of the output item
- out_illegal  out  1  output item had an illegal select code
- illegal_count  out  CNT_WIDTH  saturating count of accepted illegal items

## Operation
- Field codes (f = selected field, msb = its top bit):
  - 000: instr[7:0]
  - 001: instr[3:0]
  - 010: instr[4:0]
  - 011: instr[10:0]
  - 100: instr[4:2]
  - 101: instr[4:2]; if 000, the result is the constant 8. Always zero-extended; bit3 is ignored.
  - 110, 111: illegal; imm = 0, illegal flag = 1.
- Extension:
  - Zero mode: upper DATA_WIDTH - width(f) bits are 0.
  - Sign mode: upper bits replicate msb of f.
- Extension is computed combinationally at acceptance and stored; there is no recomputation downstream.
- Storage: output register (OUT) and skid register (SKID), each holding valid, imm, tag, and illegal.
- in_ready = !SKID.valid && !rst.
- An item is accepted when in_valid && in_ready. Routing of the accepted item:
  - If OUT is empty or out_ready, it goes to OUT.
  - Otherwise it goes to SKID.
- Output handshake: when out_ready && OUT.valid, OUT is consumed. OUT is then refilled from SKID if SKID is valid, otherwise from the input if accepted, otherwise OUT.valid goes to 0.
- SKID never holds an item while OUT is empty.
- Order is strictly FIFO: a SKID item always leaves before any newer input.
- illegal_count increments by 1 per accepted item with code 110/111 and saturates at all-ones. flush does not clear it.
- flush: OUT.valid and SKID.valid clear on the next edge. An item presented in the same cycle is dropped and not counted.
- rst has priority over flush and over all handshakes.

## Timing
- Reset values:
  - out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, illegal_count = 0.
  - SKID empty.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: an item accepted at edge N is on out_* from edge N (visible in cycle N+1) when OUT was free. There are zero bubbles at full throughput with out_ready held high.
- Stall behaviour:
  - With out_ready = 0, one further item is accepted into SKID, then in_ready drops on the next cycle.
  - After out_ready returns, in_ready reasserts one cycle after SKID drains.
- out_* remain stable while out_valid && !out_ready.
- Simultaneous consume and accept with SKID empty: the new item replaces OUT in the same edge, and SKID stays empty.
- Simultaneous consume with SKID full: SKID moves to OUT. in_ready was 0, so there is no accept that cycle.
- Reset mid-stream: all buffered items are discarded, and no partial outputs appear.

## Test plan
- Extension values, DATA_WIDTH = 16, out_ready = 1:
  - instr 0x00F5, sel 0000 -> 0x00F5.
  - sel 1000 -> 0xFFF5.
  - instr 0x0400, sel 1011 -> 0xFC00.
  - instr 0x0010, sel 1100 -> 0xFFFC.
  - instr 0x0000, sel 0101 and sel 1101 -> 0x0008.
- DATA_WIDTH = 32: instr 0x00F5, sel 1000 -> 0xFFFFFFF5; sel 0001 with instr 0x000F -> 0x0000000F.
- Back-pressure: stream tags 1,2,3,4 with out_ready low for 3 cycles mid-stream.
  - in_ready drops after exactly 2 items are buffered.
  - Outputs arrive in order 1,2,3,4 with none lost or duplicated, and out_* are stable while stalled.
- Illegal codes: 300 accepted items with sel 0110 and CNT_WIDTH = 8.
  - Each output has imm = 0 and out_illegal = 1.
  - illegal_count saturates at 255.
- Flush with OUT and SKID both full, plus a concurrent input: next cycle out_valid = 0, in_ready = 1, the concurrent item is absent, and illegal_count is unchanged.
- rst asserted mid-stall: next cycle all outputs are at reset values and in_ready = 0. One cycle after deassertion, in_ready = 1 and the first new item appears with 1-cycle latency.
